// File: rtl/if_fetch_stage_pkg.sv
// Shared defaults and constants for the instruction-fetch stage.
// Latency: n/a (types/constants only).
// Backpressure: n/a.
package if_fetch_stage_pkg;

    localparam int ISIZE_DEF  = 16;
    localparam int DSIZE_DEF  = 16;
    localparam int QDEPTH_DEF = 2;

    // Instruction presented to decode while the fetch queue is empty.
    localparam logic [DSIZE_DEF-1:0] NOP_INST = 16'h0000;

endpackage

// File: rtl/if_fetch_stage_inst_queue.sv
// Small sync FIFO of {pc, inst} words returned from instruction memory.
// Latency: a word pushed in cycle T is at the head in T+1; head comes straight from storage flops.
// Backpressure: caller guarantees no push when full; flush wins over a same-cycle push and pop.
module inst_queue #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [AW-1:0]            push_pc,
    input  logic [DW-1:0]            push_inst,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [AW-1:0]            head_pc,
    output logic [DW-1:0]            head_inst
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_inst  = inst_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns fetch PC, reads sync imem, queues words and hands {inst, pc, pc+1} to decode.
// Latency: issue at T, word queued at T+1, visible to decode at T+2; one instruction per cycle when unstalled.
// Backpressure: issue only while queued + in-flight words stay within QDEPTH; redirect flushes everything.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int               ISIZE    = ISIZE_DEF,
    parameter int               DSIZE    = DSIZE_DEF,
    parameter int               QDEPTH   = QDEPTH_DEF,
    parameter logic [ISIZE-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    input  logic             id_ready,
    output logic             imem_rd,
    output logic [ISIZE-1:0] imem_addr,
    input  logic [DSIZE-1:0] imem_data,
    output logic             if_valid,
    output logic [DSIZE-1:0] if_inst,
    output logic [ISIZE-1:0] if_pc,
    output logic [ISIZE-1:0] if_npc
);

    localparam int CW = $clog2(QDEPTH);

    logic [ISIZE-1:0] fetch_pc;
    logic [ISIZE-1:0] inflight_pc;
    logic             inflight;

    logic [CW:0]      count;
    logic [CW:0]      occupancy;
    logic             head_valid;
    logic [ISIZE-1:0] head_pc;
    logic [DSIZE-1:0] head_inst;

    logic             pop;
    logic             issue;
    logic             push;

    assign pop       = head_valid & id_ready;
    // Credit view after this cycle's pop: a new read is allowed only if its word is guaranteed a slot.
    assign occupancy = count + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue     = !rst && !redirect && (occupancy < (CW+1)'(QDEPTH));
    // A response landing in a redirect or reset cycle belongs to the old path and is dropped.
    assign push      = inflight && !redirect && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

    inst_queue #(
        .AW    (ISIZE),
        .DW    (DSIZE),
        .DEPTH (QDEPTH)
    ) u_inst_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_pc    (inflight_pc),
        .push_inst  (imem_data),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_inst  (head_inst)
    );

    assign imem_rd   = issue;
    assign imem_addr = fetch_pc;

    assign if_valid  = head_valid;
    assign if_inst   = head_valid ? head_inst : DSIZE'(NOP_INST);
    assign if_pc     = head_valid ? head_pc   : '0;
    assign if_npc    = if_pc + 1'b1;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: imem returns 16'h1000+addr one cycle after a read.
// A per-cycle scoreboard tracks the PCs decode must receive; directed literals pin the timing.
module tb_if_fetch_stage;

    localparam int QDEPTH = 2;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pc;
    logic [15:0] if_npc;

    int n_chk;
    int n_pass;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_npc      (if_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) imem_data <= 16'h1000 + imem_addr;
        else         imem_data <= 16'hDEAD;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every PC fetched since the last flush, oldest first, must reach decode in order.
    logic [15:0] exp_q[$];
    logic [15:0] exp_fetch;
    logic [15:0] h;
    bit          prev_hold;

    always @(negedge clk) begin
        if (rst) begin
            chk("rd_during_rst", 16'(imem_rd), 16'd0);
            exp_q.delete();
            exp_fetch = 16'h0000;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("stall_hold_valid", 16'(if_valid), 16'd1);
            if (if_valid) begin
                chk("head_expected", 16'(exp_q.size() != 0), 16'd1);
                if (exp_q.size() != 0) begin
                    h = exp_q[0];
                    chk("head_pc", if_pc, h);
                    chk("head_inst", if_inst, 16'h1000 + h);
                    chk("head_npc", if_npc, h + 16'd1);
                    if (id_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_inst", if_inst, 16'h0000);
                chk("idle_pc", if_pc, 16'h0000);
                chk("idle_npc", if_npc, 16'h0001);
            end
            if (redirect) begin
                chk("rd_during_redirect", 16'(imem_rd), 16'd0);
                exp_q.delete();
                exp_fetch = redirect_pc;
                prev_hold = 1'b0;
            end else begin
                if (imem_rd) begin
                    chk("fetch_addr", imem_addr, exp_fetch);
                    exp_q.push_back(exp_fetch);
                    exp_fetch = exp_fetch + 16'd1;
                    chk("credit_bound", 16'(exp_q.size() <= QDEPTH), 16'd1);
                end
                prev_hold = if_valid && !id_ready;
            end
        end
    end

    task automatic cyc(input logic r, input logic rd, input logic [15:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        @(negedge clk);
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        id_ready    = 1'b1;
        cyc(1, 0, 16'h0000, 1);
        cyc(1, 0, 16'h0000, 1);

        // 1: reset release, first valid two cycles later, then one per cycle
        cyc(0, 0, 16'h0000, 1);
        chk("t1_valid0", 16'(if_valid), 16'd0);
        chk("t1_pc0", if_pc, 16'h0000);
        chk("t1_npc0", if_npc, 16'h0001);
        chk("t1_rd0", 16'(imem_rd), 16'd1);
        chk("t1_addr0", imem_addr, 16'h0000);
        cyc(0, 0, 16'h0000, 1);
        chk("t1_valid1", 16'(if_valid), 16'd0);
        chk("t1_addr1", imem_addr, 16'h0001);
        cyc(0, 0, 16'h0000, 1);
        chk("t1_first_valid", 16'(if_valid), 16'd1);
        chk("t1_first_pc", if_pc, 16'h0000);
        chk("t1_first_inst", if_inst, 16'h1000);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 16'h0000, 1);
            chk("t1_stream_pc", if_pc, 16'(i));
        end

        // 2: stall five cycles at pc 4, then release
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 16'h0000, 0);
            chk("t2_stall_pc", if_pc, 16'h0004);
            chk("t2_stall_rd", 16'(imem_rd), 16'd0);
        end
        cyc(0, 0, 16'h0000, 1);
        chk("t2_release_pc", if_pc, 16'h0004);
        chk("t2_release_addr", imem_addr, 16'h0006);
        chk("t2_release_rd", 16'(imem_rd), 16'd1);
        for (int i = 5; i <= 8; i++) begin
            if (i == 8) cyc(0, 1, 16'h0040, 1);  // 3: redirect while pc 8 is at the head
            else        cyc(0, 0, 16'h0000, 1);
            chk("t2_after_pc", if_pc, 16'(i));
        end
        chk("t3_redirect_rd", 16'(imem_rd), 16'd0);
        cyc(0, 0, 16'h0000, 1);
        chk("t3_t1_valid", 16'(if_valid), 16'd0);
        chk("t3_t1_addr", imem_addr, 16'h0040);
        cyc(0, 0, 16'h0000, 1);
        chk("t3_t2_valid", 16'(if_valid), 16'd0);
        cyc(0, 0, 16'h0000, 1);
        chk("t3_t3_pc", if_pc, 16'h0040);
        chk("t3_t3_inst", if_inst, 16'h1040);
        cyc(0, 0, 16'h0000, 1);
        chk("t3_next_pc", if_pc, 16'h0041);

        // 4: redirect while stalled with a read in flight
        cyc(0, 1, 16'h0100, 0);
        chk("t4_head_pc", if_pc, 16'h0042);
        cyc(0, 0, 16'h0000, 0);
        chk("t4_t1_valid", 16'(if_valid), 16'd0);
        cyc(0, 0, 16'h0000, 0);
        chk("t4_t2_valid", 16'(if_valid), 16'd0);
        cyc(0, 0, 16'h0000, 0);
        chk("t4_t3_pc", if_pc, 16'h0100);
        chk("t4_t3_inst", if_inst, 16'h1100);
        cyc(0, 0, 16'h0000, 1);
        chk("t4_pop_pc", if_pc, 16'h0100);
        cyc(0, 0, 16'h0000, 1);
        chk("t4_next_pc", if_pc, 16'h0101);

        // 5: address wrap
        cyc(0, 1, 16'hFFFE, 1);
        cyc(0, 0, 16'h0000, 1);
        chk("t5_addr", imem_addr, 16'hFFFE);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);
        chk("t5_pc_fffe", if_pc, 16'hFFFE);
        chk("t5_npc_fffe", if_npc, 16'hFFFF);
        cyc(0, 0, 16'h0000, 1);
        chk("t5_pc_ffff", if_pc, 16'hFFFF);
        chk("t5_npc_ffff", if_npc, 16'h0000);
        chk("t5_inst_ffff", if_inst, 16'h0FFF);
        cyc(0, 0, 16'h0000, 1);
        chk("t5_pc_0000", if_pc, 16'h0000);
        chk("t5_inst_0000", if_inst, 16'h1000);

        // 6: reset mid-stream with a read in flight
        cyc(1, 0, 16'h0000, 1);
        chk("t6_rst_rd", 16'(imem_rd), 16'd0);
        cyc(0, 0, 16'h0000, 1);
        chk("t6_t1_valid", 16'(if_valid), 16'd0);
        chk("t6_t1_addr", imem_addr, 16'h0000);
        cyc(0, 0, 16'h0000, 1);
        chk("t6_t2_valid", 16'(if_valid), 16'd0);
        cyc(0, 0, 16'h0000, 1);
        chk("t6_t3_valid", 16'(if_valid), 16'd1);
        chk("t6_t3_pc", if_pc, 16'h0000);
        cyc(0, 0, 16'h0000, 1);
        chk("t6_next_pc", if_pc, 16'h0001);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
